alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result; all widths below use WIDTH = 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_aluop  input  2  00 add (load/store address), 01 subtract (branch compare), 10 decode by funct, 11 illegal.
REQ-007 req_funct  input  6  R-type function field; used only when req_aluop=10.
REQ-008 req_a, req_b  input  32 each  operands.
REQ-009 alu_ctrl  output  3  operation code driven to the ALU.
REQ-010 alu_a, alu_b  output  32 each  operands driven to the ALU.
REQ-011 alu_result  input  32  combinational ALU result.
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_result  output  32  captured ALU result.
REQ-016 resp_zero  output  1  captured zero flag.
REQ-017 resp_taken  output  1  branch taken: req_aluop was 01 and captured zero = 1.
REQ-018 resp_error  output  1  request had an illegal aluop/funct.
REQ-019 op_count  output  16  number of responses consumed.

Function
REQ-020 FSM states IDLE, EXEC, RESP; a request is accepted on a rising edge with req_valid and req_ready both high.
REQ-021 Decode on acceptance: aluop 00 -> 010; aluop 01 -> 110; aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-022 Decode errors: aluop 11, or aluop 10 with any other funct.
REQ-023 Legal request accepted at edge N: alu_ctrl, alu_a and alu_b register the decoded code and operands at edge N, and the FSM enters EXEC.
REQ-024 EXEC lasts exactly one cycle; at edge N+1, resp_result, resp_zero and resp_taken capture the ALU values and the FSM enters RESP, so resp_valid is high from N+1.
REQ-025 Illegal request accepted at edge N: the FSM skips EXEC and enters RESP at edge N with resp_error=1, resp_result=0, resp_zero=0 and resp_taken=0; alu_* outputs are unchanged.
REQ-026 A legal request clears resp_error when its response is captured.
REQ-027 RESP: all resp_* outputs are held stable while resp_valid is high and resp_ready is low; backpressure has no depth limit.
REQ-028 On a rising edge in RESP with resp_ready high: the FSM returns to IDLE, resp_valid falls, and op_count increments.
REQ-029 op_count wraps from 0xFFFF to 0x0000; error responses are counted.
REQ-030 No request is accepted in EXEC or RESP; a request arriving then waits, and back-to-back throughput is 1 request per 3 cycles (2 for illegal requests).
REQ-031 alu_ctrl, alu_a and alu_b hold their last values outside EXEC; resp_result, resp_zero, resp_taken and resp_error hold after the response is consumed.
REQ-032 The block performs no arithmetic itself; resp_result and resp_zero are exactly the alu_result and alu_zero values sampled at the end of EXEC.

Reset
REQ-033 While reset is high, the FSM is in IDLE, all outputs are 0 and req_ready is 1, independent of clk.
REQ-034 Reset asserted in EXEC or RESP aborts the operation immediately: the pending response is discarded and op_count is not incremented.
REQ-035 After reset deasserts, the first rising edge may accept a request.

Verification
REQ-036 aluop=10, funct=100010, a=7, b=9, resp_ready=1 -> alu_ctrl=110 during EXEC, resp_result=0xFFFFFFFE, resp_zero=0, resp_valid at N+1, op_count=1.
REQ-037 aluop=01, a=b=0x1234 -> alu_ctrl=110, resp_zero=1, resp_taken=1; then aluop=00 with the same operands -> resp_taken=0, resp_result=0x2468.
REQ-038 aluop=10, funct=000000 -> resp_valid at N, resp_error=1, resp_result=0, no EXEC cycle, alu_* unchanged.
REQ-039 resp_ready low for 5 cycles with req_valid held high -> resp_* stable, req_ready=0, second request accepted the edge after RESP exits.
REQ-040 Reset pulse during EXEC -> resp_valid=0, req_ready=1, op_count unchanged, alu_ctrl=000.
REQ-041 Preload 0xFFFF completed responses (or force the counter) then complete one more -> op_count=0x0000.

Source files
------------

// File: rtl/alu_sequencer.sv
// Request/response sequencer that decodes an ALU op, drives an external combinational ALU
// for one cycle and holds the captured result until the consumer accepts it.
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_taken,
    output logic             resp_error,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             is_branch_q, is_branch_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;
    logic             resp_taken_q, resp_taken_d;
    logic             resp_error_q, resp_error_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             dec_err;
    logic [2:0]       dec_ctrl;

    // Returns {error, alu control code}.
    function automatic logic [3:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] r;
        r = 4'b1_000;
        case (aluop)
            2'b00: r = 4'b0_010;
            2'b01: r = 4'b0_110;
            2'b10: begin
                case (funct)
                    6'b100000: r = 4'b0_010;
                    6'b100010: r = 4'b0_110;
                    6'b100100: r = 4'b0_000;
                    6'b100101: r = 4'b0_001;
                    6'b101010: r = 4'b0_111;
                    default:   r = 4'b1_000;
                endcase
            end
            default: r = 4'b1_000;
        endcase
        return r;
    endfunction

    assign {dec_err, dec_ctrl} = decode(req_aluop, req_funct);

    always_comb begin
        state_d       = state_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        is_branch_d   = is_branch_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_taken_d  = resp_taken_q;
        resp_error_d  = resp_error_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_err) begin
                        // Illegal requests bypass the ALU and leave its inputs untouched.
                        state_d       = RESP;
                        resp_error_d  = 1'b1;
                        resp_result_d = '0;
                        resp_zero_d   = 1'b0;
                        resp_taken_d  = 1'b0;
                    end else begin
                        state_d     = EXEC;
                        alu_ctrl_d  = dec_ctrl;
                        alu_a_d     = req_a;
                        alu_b_d     = req_b;
                        is_branch_d = (req_aluop == 2'b01);
                    end
                end
            end
            EXEC: begin
                state_d       = RESP;
                resp_result_d = alu_result;
                resp_zero_d   = alu_zero;
                resp_taken_d  = is_branch_q & alu_zero;
                resp_error_d  = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            alu_ctrl_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            is_branch_q   <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            is_branch_q   <= is_branch_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_taken_q  <= resp_taken_d;
            resp_error_q  <= resp_error_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_taken  = resp_taken_q;
    assign resp_error  = resp_error_q;
    assign op_count    = op_count_q;

endmodule
